// File: rtl/gaussian_input_feeder.sv
// Input feeder for the gaussian accelerator: a show-ahead pixel FIFO behind a
// valid/ready host stream, served to a pull-style port, with frame and underrun tracking.
module gaussian_input_feeder #(
  parameter int WIDTH        = 16,
  parameter int DEPTH        = 16,
  parameter int FRAME_PIXELS = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en,
  output logic [WIDTH-1:0]           hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read [0:0],
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       frame_done,
  output logic                       underrun
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int CW = $clog2(FRAME_PIXELS+1);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(FRAME_PIXELS-1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    pix_cnt;
  logic             clr;
  logic             push;
  logic             pop;
  logic             rd_en;

  assign rd_en = hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en;
  assign clr   = !rst_n || flush;

  // Ready depends only on registered occupancy, never on the pop request.
  assign in_ready = !clr && (level != FULL);
  assign push     = in_valid && in_ready;
  assign pop      = rd_en && (level != '0);

  assign hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read[0] =
    (level == '0) ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      pix_cnt    <= '0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      frame_done <= pop && (pix_cnt == LAST);
      if (pop) begin
        pix_cnt <= (pix_cnt == LAST) ? '0 : pix_cnt + 1'b1;
      end
      if (rd_en && (level == '0)) begin
        underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gaussian_input_feeder.sv
// Scoreboard bench for gaussian_input_feeder: accepted pushes queue expected
// pixels, a negedge monitor checks every pop and logs frame_done positions.
module tb_gaussian_input_feeder;

  localparam int W  = 16;
  localparam int D  = 16;
  localparam int FP = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         rd_en;
  logic [W-1:0] rd [0:0];
  logic [4:0]   level;
  logic         frame_done;
  logic         underrun;

  int errors = 0;
  int checks = 0;
  int pops_done = 0;
  logic [W-1:0] exp_q [$];
  int fd_at [$];

  always #5 clk = ~clk;

  gaussian_input_feeder #(.WIDTH(W), .DEPTH(D), .FRAME_PIXELS(FP)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en(rd_en),
    .hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read(rd),
    .level(level),
    .frame_done(frame_done),
    .underrun(underrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: drained/cleared on reset or flush, otherwise scores pops.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      exp_q.delete();
      pops_done = 0;
    end else begin
      if (frame_done) fd_at.push_back(pops_done);
      if (rd_en && level != 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_data: got %0d expected none queued", rd[0]);
        end else begin
          check("pop_data", 32'(rd[0]), 32'(exp_q.pop_front()));
        end
        pops_done++;
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = W'(base + k);
      rd_en    = (k > 0);
      step();
      check("stream_level", 32'(level), 32'd1);
    end
    in_valid = 1'b0;
    rd_en    = 1'b1;
    step();
    rd_en = 1'b0;
    step();
    check("drain_level", 32'(level), 32'd0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    check("flush_level", 32'(level), 32'd0);
    check("flush_underrun", 32'(underrun), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    rst_n    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'd5;
    rd_en    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_level", 32'(level), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_read", 32'(rd[0]), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    rd_en    = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    step();

    stream(10, 0);
    check("stream_underrun", 32'(underrun), 32'd0);
    check("empty_read", 32'(rd[0]), 32'd0);

    for (int i = 0; i < D; i++) begin
      in_valid = 1'b1;
      in_data  = W'(100 + i);
      step();
    end
    check("full_level", 32'(level), 32'd16);
    check("full_in_ready", 32'(in_ready), 32'd0);
    in_data = 16'd200;
    step();
    check("held_level", 32'(level), 32'd16);
    rd_en = 1'b1;
    step();
    check("pop_full_level", 32'(level), 32'd15);
    check("pop_full_in_ready", 32'(in_ready), 32'd1);
    rd_en = 1'b0;
    step();
    check("refill_level", 32'(level), 32'd16);
    in_valid = 1'b0;
    rd_en    = 1'b1;
    repeat (D) step();
    rd_en = 1'b0;
    check("fill_drain_level", 32'(level), 32'd0);

    do_flush();
    fd_at.delete();
    stream(16, 300);
    check("frame_pulses", 32'(fd_at.size()), 32'd2);
    if (fd_at.size() == 2) begin
      check("frame_pulse0", 32'(fd_at[0]), 32'd8);
      check("frame_pulse1", 32'(fd_at[1]), 32'd16);
    end

    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("underrun_set", 32'(underrun), 32'd1);
    step();
    check("underrun_sticky", 32'(underrun), 32'd1);
    fd_at.delete();
    base = pops_done;
    stream(8, 400);
    check("underrun_cnt_pulses", 32'(fd_at.size()), 32'd1);
    if (fd_at.size() == 1) begin
      check("underrun_cnt_pos", 32'(fd_at[0] - base), 32'd8);
    end
    check("underrun_still", 32'(underrun), 32'd1);
    do_flush();

    fd_at.delete();
    stream(5, 500);
    do_flush();
    stream(8, 600);
    check("midflush_pulses", 32'(fd_at.size()), 32'd1);
    if (fd_at.size() == 1) begin
      check("midflush_pos", 32'(fd_at[0]), 32'd8);
    end
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
